ram_access_arbiter: RTL and testbench

//  Sequences the 32x8 asynchronous RAM (active-low CS/OE/WS, shared bidirectional DATA bus).
//  Two requesters (A, B) share the RAM through round-robin arbitration.

---
 rtl/ram_access_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_ram_access_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter and access sequencer for a 32x8 asynchronous RAM.
// Every access runs SETUP -> STROBE x STROBE_CYCLES -> HOLD; all pins come straight from flops.
module ram_access_arbiter #(
  parameter int unsigned ADDR_W        = 5,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_done,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_done,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              ram_cs_n,
  output logic              ram_oe_n,
  output logic              ram_ws_n,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data
);

  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                owner_b_q, owner_b_d;
  logic                last_b_q, last_b_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                drive_q, drive_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                busy_q, busy_d;
  logic                cs_n_q, cs_n_d;
  logic                oe_n_q, oe_n_d;
  logic                ws_n_q, ws_n_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                a_gnt_q, a_gnt_d;
  logic                b_gnt_q, b_gnt_d;
  logic                a_done_q, a_done_d;
  logic                b_done_q, b_done_d;

  logic                pick_a, pick_b;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_b_d = owner_b_q;
    last_b_d  = last_b_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    drive_d   = drive_q;
    rdata_d   = rdata_q;
    busy_d    = busy_q;
    cs_n_d    = cs_n_q;
    oe_n_d    = oe_n_q;
    ws_n_d    = ws_n_q;
    addr_d    = addr_q;
    a_gnt_d   = 1'b0;
    b_gnt_d   = 1'b0;
    a_done_d  = 1'b0;
    b_done_d  = 1'b0;

    // On a tie the requester that was not served last wins.
    pick_a    = a_req && (!b_req || last_b_q);
    pick_b    = b_req && !pick_a;
    sel_we    = pick_a ? a_we    : b_we;
    sel_addr  = pick_a ? a_addr  : b_addr;
    sel_wdata = pick_a ? a_wdata : b_wdata;

    unique case (state_q)
      StIdle: begin
        if (pick_a || pick_b) begin
          state_d   = StSetup;
          owner_b_d = pick_b;
          we_d      = sel_we;
          wdata_d   = sel_wdata;
          addr_d    = sel_addr;
          drive_d   = sel_we;
          busy_d    = 1'b1;
          cs_n_d    = 1'b0;
          oe_n_d    = sel_we;
          ws_n_d    = 1'b1;
          a_gnt_d   = pick_a;
          b_gnt_d   = pick_b;
        end
      end
      StSetup: begin
        state_d = StStrobe;
        cnt_d   = CntW'(STROBE_CYCLES - 1);
        ws_n_d  = !we_q;
      end
      StStrobe: begin
        if (cnt_q == '0) begin
          state_d = StHold;
          ws_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          // Sample read data while OE_n is still asserted.
          if (!we_q) begin
            rdata_d = ram_data;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHold: begin
        state_d  = StIdle;
        cs_n_d   = 1'b1;
        drive_d  = 1'b0;
        busy_d   = 1'b0;
        a_done_d = !owner_b_q;
        b_done_d = owner_b_q;
        last_b_d = owner_b_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      owner_b_q <= 1'b0;
      last_b_q  <= 1'b1;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      drive_q   <= 1'b0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      ws_n_q    <= 1'b1;
      addr_q    <= '0;
      a_gnt_q   <= 1'b0;
      b_gnt_q   <= 1'b0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_b_q <= owner_b_d;
      last_b_q  <= last_b_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      drive_q   <= drive_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      cs_n_q    <= cs_n_d;
      oe_n_q    <= oe_n_d;
      ws_n_q    <= ws_n_d;
      addr_q    <= addr_d;
      a_gnt_q   <= a_gnt_d;
      b_gnt_q   <= b_gnt_d;
      a_done_q  <= a_done_d;
      b_done_q  <= b_done_d;
    end
  end

  assign ram_data = drive_q ? wdata_q : {DATA_W{1'bz}};
  assign a_gnt    = a_gnt_q;
  assign b_gnt    = b_gnt_q;
  assign a_done   = a_done_q;
  assign b_done   = b_done_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign ram_cs_n = cs_n_q;
  assign ram_oe_n = oe_n_q;
  assign ram_ws_n = ws_n_q;
  assign ram_addr = addr_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter: cycle tables for single accesses, hand sequences for
// reset, arbitration alternation and a full-array sweep against a behavioural async RAM.
module tb_ram_access_arbiter;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 8;
  localparam int unsigned S  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_gnt, a_done, b_gnt, b_done, busy;
  logic [DW-1:0] rdata;
  logic          ram_cs_n, ram_oe_n, ram_ws_n;
  logic [AW-1:0] ram_addr;
  wire  [DW-1:0] ram_data;

  logic [DW-1:0] mem [32];
  int unsigned   n_vec = 0;
  int unsigned   n_bad = 0;
  bit            mon_en = 1'b0;

  always #5 clk = ~clk;

  ram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STROBE_CYCLES(S)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done),
    .rdata(rdata), .busy(busy),
    .ram_cs_n(ram_cs_n), .ram_oe_n(ram_oe_n), .ram_ws_n(ram_ws_n),
    .ram_addr(ram_addr), .ram_data(ram_data)
  );

  // Released bus floats high, so an undriven bus reads all ones.
  for (genvar i = 0; i < DW; i++) begin : g_pu
    pullup (ram_data[i]);
  end

  // Asynchronous RAM model.
  assign ram_data = (!ram_cs_n && !ram_oe_n) ? mem[ram_addr] : {DW{1'bz}};
  always @(posedge clk) begin
    if (!ram_cs_n && !ram_ws_n) mem[ram_addr] <= ram_data;
  end

  // Per-cycle protocol monitor.
  logic prev_ag = 1'b0, prev_ad = 1'b0, prev_bg = 1'b0, prev_bd = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (!ram_oe_n && !ram_ws_n) begin
        n_bad++;
        $display("FAIL strobe_overlap: oe_n=%0b ws_n=%0b, required not both 0", ram_oe_n, ram_ws_n);
      end
      if ((a_gnt && prev_ag) || (a_done && prev_ad) || (b_gnt && prev_bg) || (b_done && prev_bd)) begin
        n_bad++;
        $display("FAIL pulse_width: gnt/done high two cycles, required single-cycle pulses");
      end
      if (ram_cs_n && ram_data !== {DW{1'b1}}) begin
        n_bad++;
        $display("FAIL bus_idle: ram_data=%0h while cs_n=1, required released (ff)", ram_data);
      end
      if (!ram_cs_n && !ram_oe_n && ram_data !== mem[ram_addr]) begin
        n_bad++;
        $display("FAIL bus_read: ram_data=%0h, required RAM value %0h", ram_data, mem[ram_addr]);
      end
    end
    prev_ag <= a_gnt;
    prev_ad <= a_done;
    prev_bg <= b_gnt;
    prev_bd <= b_done;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete access from requester A or B; checks grant/done latency.
  task automatic access(input bit use_b, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd);
    int t;
    if (use_b) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; end
    else       begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; end
    t = 0;
    do begin cyc(); t++; end while (!(use_b ? b_gnt : a_gnt) && t < 20);
    check("gnt_seen", {31'd0, use_b ? b_gnt : a_gnt}, 32'd1);
    a_req = 1'b0;
    b_req = 1'b0;
    t = 0;
    while (!(use_b ? b_done : a_done) && t < 20) begin cyc(); t++; end
    check("done_latency", t, S + 2);
  endtask

  typedef struct packed {
    logic          a_req, a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          b_req, b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic [7:0]    ctl;    // {a_gnt, a_done, b_gnt, b_done, busy, cs_n, oe_n, ws_n}
    logic [AW-1:0] addr;   // compared only while cs_n is expected low
    logic [DW-1:0] rd;
    logic [DW-1:0] bus;
  } vec_t;

  vec_t vt [12];

  initial begin
    // A writes A5 to 5 (inputs scrambled after grant), then B reads it back.
    vt[0]  = '{1, 1, 5'd5, 8'hA5, 0, 0, 5'd0, 8'h00, 8'b1000_1011, 5'd5, 8'h00, 8'hA5};
    vt[1]  = '{0, 0, 5'd7, 8'h3C, 0, 0, 5'd0, 8'h00, 8'b0000_1010, 5'd5, 8'h00, 8'hA5};
    vt[2]  = '{0, 0, 5'd7, 8'h3C, 0, 0, 5'd0, 8'h00, 8'b0000_1010, 5'd5, 8'h00, 8'hA5};
    vt[3]  = '{0, 0, 5'd7, 8'h3C, 0, 0, 5'd0, 8'h00, 8'b0000_1011, 5'd5, 8'h00, 8'hA5};
    vt[4]  = '{0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00, 8'b0100_0111, 5'd0, 8'h00, 8'hFF};
    vt[5]  = '{0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00, 8'b0000_0111, 5'd0, 8'h00, 8'hFF};
    vt[6]  = '{0, 0, 5'd0, 8'h00, 1, 0, 5'd5, 8'h77, 8'b0010_1001, 5'd5, 8'h00, 8'hA5};
    vt[7]  = '{0, 0, 5'd0, 8'h00, 0, 1, 5'd9, 8'h77, 8'b0000_1001, 5'd5, 8'h00, 8'hA5};
    vt[8]  = '{0, 0, 5'd0, 8'h00, 0, 1, 5'd9, 8'h77, 8'b0000_1001, 5'd5, 8'h00, 8'hA5};
    vt[9]  = '{0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00, 8'b0000_1011, 5'd5, 8'hA5, 8'hFF};
    vt[10] = '{0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00, 8'b0001_0111, 5'd0, 8'hA5, 8'hFF};
    vt[11] = '{0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00, 8'b0000_0111, 5'd0, 8'hA5, 8'hFF};

    // Reset, then reset again in the middle of a write strobe.
    @(negedge clk);
    cyc();
    cyc();
    rst = 1'b0;
    mon_en = 1'b1;
    check("reset_ctl", {a_gnt, a_done, b_gnt, b_done, busy, ram_cs_n, ram_oe_n, ram_ws_n},
          8'b0000_0111);
    check("reset_addr", ram_addr, 0);
    check("reset_rdata", rdata, 0);
    a_req = 1'b1; a_we = 1'b1; a_addr = 5'd9; a_wdata = 8'h33;
    cyc();
    check("mid_gnt", a_gnt, 1);
    a_req = 1'b0;
    cyc();
    check("mid_ws_low", ram_ws_n, 0);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("rst_abort_ctl", {a_done, busy, ram_cs_n, ram_oe_n, ram_ws_n}, 5'b0_0111);
      check("rst_abort_bus", ram_data, 8'hFF);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("rst_no_done", {a_done, busy}, 2'b00);
    end

    // Single write then single read, cycle by cycle.
    for (int i = 0; i < 12; i++) begin
      a_req = vt[i].a_req; a_we = vt[i].a_we; a_addr = vt[i].a_addr; a_wdata = vt[i].a_wdata;
      b_req = vt[i].b_req; b_we = vt[i].b_we; b_addr = vt[i].b_addr; b_wdata = vt[i].b_wdata;
      cyc();
      check($sformatf("vec%0d_ctl", i),
            {a_gnt, a_done, b_gnt, b_done, busy, ram_cs_n, ram_oe_n, ram_ws_n}, vt[i].ctl);
      if (vt[i].ctl[2] == 1'b0) check($sformatf("vec%0d_addr", i), ram_addr, vt[i].addr);
      check($sformatf("vec%0d_rdata", i), rdata, vt[i].rd);
      check($sformatf("vec%0d_bus", i), ram_data, vt[i].bus);
    end
    check("mem5", mem[5], 8'hA5);

    // Both requesting from reset: A first, then strict alternation every S+3 cycles.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 5'd1; a_wdata = 8'h11;
    b_req = 1'b1; b_we = 1'b1; b_addr = 5'd2; b_wdata = 8'h22;
    for (int k = 0; k < 20; k++) begin
      cyc();
      check($sformatf("rr_k%0d", k), {a_gnt, a_done, b_gnt, b_done},
            {k % 10 == 0, k % 10 == 4, k % 10 == 5, k % 10 == 9});
    end
    a_req = 1'b0;
    b_req = 1'b0;
    for (int k = 0; k < 3; k++) cyc();
    check("rr_mem1", mem[1], 8'h11);
    check("rr_mem2", mem[2], 8'h22);
    check("rr_rdata_kept", rdata, 8'h00);

    // Full sweep: A writes data=addr everywhere, B reads it all back, then 31 -> 0 wrap.
    for (int i = 0; i < 32; i++) access(1'b0, 1'b1, AW'(i), DW'(i));
    for (int i = 0; i < 32; i++) begin
      access(1'b1, 1'b0, AW'(i), 8'h00);
      check($sformatf("sweep_rd%0d", i), rdata, i);
    end
    access(1'b0, 1'b0, 5'd31, 8'h00);
    check("wrap_rd31", rdata, 31);
    access(1'b1, 1'b0, 5'd0, 8'h00);
    check("wrap_rd0", rdata, 0);
    access(1'b0, 1'b1, 5'd31, 8'hC3);
    check("write_keeps_rdata", rdata, 0);
    check("mem31", mem[31], 8'hC3);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
